// File: rtl/udp_arb_pkg.sv
// Shared types and field widths for the UDP TX arbiter.
package udp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } arb_state_t;

  localparam int UDP_PORT_W = 16;
  localparam int IP_ADDR_W  = 32;
  localparam int IP_PROTO_W = 8;

endpackage

// File: rtl/udp_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter  int NUM_PORTS = 4,
  localparam int GW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        last_grant,
  output logic [GW-1:0]        grant,
  output logic                 any_req
);

  localparam logic [GW:0] NP = (GW+1)'(NUM_PORTS);

  logic [GW:0] cand;

  always_comb begin
    grant   = last_grant;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, last_grant} + (GW+1)'(k);
      if (cand >= NP) begin
        cand = cand - NP;
      end
      if (!any_req && req[cand[GW-1:0]]) begin
        any_req = 1'b1;
        grant   = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin sharing of one UDP TX header+payload path, grant held per packet.
// Optional per-port packet counters when UDP_TX_ARB_STATS_EN is defined.
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter  int NUM_PORTS      = 4,
  parameter  int AXI_DATA_WIDTH = 8,
  localparam int GW             = $clog2(NUM_PORTS)
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [NUM_PORTS-1:0]                s_hdr_tvalid,
  output logic [NUM_PORTS-1:0]                s_hdr_trdy,
  input  logic [UDP_PORT_W*NUM_PORTS-1:0]     s_udp_src_port,
  input  logic [UDP_PORT_W*NUM_PORTS-1:0]     s_udp_dst_port,
  input  logic [IP_ADDR_W*NUM_PORTS-1:0]      s_ip_src_ip_addr,
  input  logic [IP_ADDR_W*NUM_PORTS-1:0]      s_ip_dst_ip_addr,
  input  logic [IP_PROTO_W*NUM_PORTS-1:0]     s_ip_protocol,
  input  logic [AXI_DATA_WIDTH*NUM_PORTS-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                s_axis_tlast,
  output logic [NUM_PORTS-1:0]                s_axis_trdy,
  output logic                                m_hdr_tvalid,
  input  logic                                m_hdr_trdy,
  output logic [UDP_PORT_W-1:0]               m_udp_src_port,
  output logic [UDP_PORT_W-1:0]               m_udp_dst_port,
  output logic [IP_ADDR_W-1:0]                m_ip_src_ip_addr,
  output logic [IP_ADDR_W-1:0]                m_ip_dst_ip_addr,
  output logic [IP_PROTO_W-1:0]               m_ip_protocol,
  output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_trdy,
  output logic [GW-1:0]                       m_grant,
  output logic                                m_busy
`ifdef UDP_TX_ARB_STATS_EN
  ,
  output logic [32*NUM_PORTS-1:0]             m_pkt_count
`endif
);

  arb_state_t    state_reg, state_next;
  logic [GW-1:0] grant_reg, last_grant_reg;
  logic [GW-1:0] arb_grant;
  logic          arb_any;
  logic          hdr_done, pkt_done;

  logic [UDP_PORT_W-1:0]     src_port_arr [NUM_PORTS];
  logic [UDP_PORT_W-1:0]     dst_port_arr [NUM_PORTS];
  logic [IP_ADDR_W-1:0]      src_ip_arr   [NUM_PORTS];
  logic [IP_ADDR_W-1:0]      dst_ip_arr   [NUM_PORTS];
  logic [IP_PROTO_W-1:0]     proto_arr    [NUM_PORTS];
  logic [AXI_DATA_WIDTH-1:0] data_arr     [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign src_port_arr[gi] = s_udp_src_port[UDP_PORT_W*gi +: UDP_PORT_W];
      assign dst_port_arr[gi] = s_udp_dst_port[UDP_PORT_W*gi +: UDP_PORT_W];
      assign src_ip_arr[gi]   = s_ip_src_ip_addr[IP_ADDR_W*gi +: IP_ADDR_W];
      assign dst_ip_arr[gi]   = s_ip_dst_ip_addr[IP_ADDR_W*gi +: IP_ADDR_W];
      assign proto_arr[gi]    = s_ip_protocol[IP_PROTO_W*gi +: IP_PROTO_W];
      assign data_arr[gi]     = s_axis_tdata[AXI_DATA_WIDTH*gi +: AXI_DATA_WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr (
    .req        (s_hdr_tvalid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  // Handshakes are taken from the inputs directly to keep the mux out of the feedback path.
  assign hdr_done = (state_reg == HDR) && s_hdr_tvalid[grant_reg] && m_hdr_trdy;
  assign pkt_done = (state_reg == PAYLOAD) && s_axis_tvalid[grant_reg] &&
                    s_axis_tlast[grant_reg] && m_axis_trdy;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_PORTS - 1);
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && arb_any) begin
        grant_reg <= arb_grant;
      end
      if (pkt_done) begin
        last_grant_reg <= grant_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_any)  state_next = HDR;
      HDR:     if (hdr_done) state_next = PAYLOAD;
      PAYLOAD: if (pkt_done) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    m_hdr_tvalid     = 1'b0;
    m_udp_src_port   = '0;
    m_udp_dst_port   = '0;
    m_ip_src_ip_addr = '0;
    m_ip_dst_ip_addr = '0;
    m_ip_protocol    = '0;
    m_axis_tdata     = '0;
    m_axis_tvalid    = 1'b0;
    m_axis_tlast     = 1'b0;
    s_hdr_trdy       = '0;
    s_axis_trdy      = '0;
    if (state_reg == HDR) begin
      m_hdr_tvalid          = s_hdr_tvalid[grant_reg];
      m_udp_src_port        = src_port_arr[grant_reg];
      m_udp_dst_port        = dst_port_arr[grant_reg];
      m_ip_src_ip_addr      = src_ip_arr[grant_reg];
      m_ip_dst_ip_addr      = dst_ip_arr[grant_reg];
      m_ip_protocol         = proto_arr[grant_reg];
      s_hdr_trdy[grant_reg] = m_hdr_trdy;
    end
    if (state_reg == PAYLOAD) begin
      m_axis_tdata           = data_arr[grant_reg];
      m_axis_tvalid          = s_axis_tvalid[grant_reg];
      m_axis_tlast           = s_axis_tlast[grant_reg];
      s_axis_trdy[grant_reg] = m_axis_trdy;
    end
  end

  assign m_busy  = (state_reg != IDLE);
  assign m_grant = m_busy ? grant_reg : '0;

`ifdef UDP_TX_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
      localparam logic [GW-1:0] PORT_ID = GW'(gi);
      logic [31:0] cnt_reg;
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          cnt_reg <= '0;
        end else if (pkt_done && (grant_reg == PORT_ID)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
      assign m_pkt_count[32*gi +: 32] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomised requesters against a packet-level round-robin model for udp_tx_arbiter.
module tb_udp_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int GW = $clog2(N);

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [N-1:0]     s_hdr_tvalid, s_hdr_trdy;
  logic [16*N-1:0]  s_udp_src_port, s_udp_dst_port;
  logic [32*N-1:0]  s_ip_src_ip_addr, s_ip_dst_ip_addr;
  logic [8*N-1:0]   s_ip_protocol;
  logic [W*N-1:0]   s_axis_tdata;
  logic [N-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_trdy;
  logic             m_hdr_tvalid, m_hdr_trdy;
  logic [15:0]      m_udp_src_port, m_udp_dst_port;
  logic [31:0]      m_ip_src_ip_addr, m_ip_dst_ip_addr;
  logic [7:0]       m_ip_protocol;
  logic [W-1:0]     m_axis_tdata;
  logic             m_axis_tvalid, m_axis_tlast, m_axis_trdy;
  logic [GW-1:0]    m_grant;
  logic             m_busy;
`ifdef UDP_TX_ARB_STATS_EN
  logic [32*N-1:0]  m_pkt_count;
`endif

  udp_tx_arbiter #(.NUM_PORTS(N), .AXI_DATA_WIDTH(W)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_trdy(s_hdr_trdy),
    .s_udp_src_port(s_udp_src_port), .s_udp_dst_port(s_udp_dst_port),
    .s_ip_src_ip_addr(s_ip_src_ip_addr), .s_ip_dst_ip_addr(s_ip_dst_ip_addr),
    .s_ip_protocol(s_ip_protocol),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_trdy(s_axis_trdy),
    .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_trdy(m_hdr_trdy),
    .m_udp_src_port(m_udp_src_port), .m_udp_dst_port(m_udp_dst_port),
    .m_ip_src_ip_addr(m_ip_src_ip_addr), .m_ip_dst_ip_addr(m_ip_dst_ip_addr),
    .m_ip_protocol(m_ip_protocol),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_trdy(m_axis_trdy),
    .m_grant(m_grant), .m_busy(m_busy)
`ifdef UDP_TX_ARB_STATS_EN
    , .m_pkt_count(m_pkt_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Requester-side model: packets queued per port, current header and byte index.
  int          pend [N], phase [N], idx [N], len [N], seq [N], fix_len [N], done_cnt [N];
  bit          hold [N], hs_hdr [N], hs_ax [N];
  logic [15:0] h_src [N], h_dst [N];
  logic [31:0] h_sip [N], h_dip [N];
  logic [7:0]  h_proto [N];
  int          last_sent, rdy_mode, out_bytes, out_pkts, exp_bytes, exp_pkts;
  bit          prev_busy, tog, aborted;
  logic [N-1:0] snap;
  logic [31:0] grant_code, salt;
  int          n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_val(input int p, input int s, input int i);
    return 8'(p * 37 + s * 11 + i * 5 + int'(salt));
  endfunction

  // Winner = first requesting port strictly after the last port that finished a packet.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    int p;
    for (int k = 1; k <= N; k++) begin
      p = (last + k) % N;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  function automatic int total_pend();
    int t = 0;
    for (int p = 0; p < N; p++) t += pend[p];
    return t;
  endfunction

  task automatic new_header(input int p);
    h_src[p]   = 16'($urandom);
    h_dst[p]   = 16'($urandom);
    h_sip[p]   = $urandom;
    h_dip[p]   = $urandom;
    h_proto[p] = 8'($urandom);
    len[p]     = (fix_len[p] > 0) ? fix_len[p] : int'($urandom_range(1, 6));
    idx[p]     = 0;
  endtask

  task automatic enqueue(input int p, input int count, input int flen);
    fix_len[p] = flen;
    if (pend[p] == 0) new_header(p);
    pend[p] += count;
  endtask

  task automatic reset_model();
    for (int p = 0; p < N; p++) begin
      pend[p] = 0; phase[p] = 0; idx[p] = 0; seq[p] = 0; fix_len[p] = 0;
      done_cnt[p] = 0; hold[p] = 0; len[p] = 1;
    end
    last_sent = N - 1; prev_busy = 0; snap = '0;
    out_bytes = 0; out_pkts = 0; exp_bytes = 0; exp_pkts = 0;
  endtask

  task automatic drive();
    bit v;
    tog = ~tog;
    m_hdr_trdy  = (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    m_axis_trdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? tog : ($urandom_range(0, 3) != 0);
    for (int p = 0; p < N; p++) begin
      s_hdr_tvalid[p]            = (pend[p] > 0) && (phase[p] == 0);
      s_udp_src_port[16*p +: 16] = h_src[p];
      s_udp_dst_port[16*p +: 16] = h_dst[p];
      s_ip_src_ip_addr[32*p +: 32] = h_sip[p];
      s_ip_dst_ip_addr[32*p +: 32] = h_dip[p];
      s_ip_protocol[8*p +: 8]    = h_proto[p];
      v = (phase[p] == 1) && (hold[p] || rdy_mode == 2 || $urandom_range(0, 3) != 0);
      s_axis_tvalid[p]           = v;
      s_axis_tdata[W*p +: W]     = byte_val(p, seq[p], idx[p]);
      s_axis_tlast[p]            = (idx[p] == len[p] - 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {m_hdr_tvalid, m_udp_src_port, m_udp_dst_port, m_ip_src_ip_addr,
                m_ip_dst_ip_addr, m_ip_protocol, m_axis_tdata, m_axis_tvalid,
                m_axis_tlast, m_grant, m_busy, s_hdr_trdy, s_axis_trdy}, '0);
  endtask

  task automatic sample_and_check();
    int g, e;
    logic [N-1:0] mask;
    for (int p = 0; p < N; p++) begin
      hs_hdr[p] = s_hdr_tvalid[p] && s_hdr_trdy[p];
      hs_ax[p]  = s_axis_tvalid[p] && s_axis_trdy[p];
    end
    if (m_axis_tvalid && m_axis_trdy) begin
      out_bytes++;
      if (m_axis_tlast) out_pkts++;
    end
    if (!m_busy) begin
      snap = s_hdr_tvalid;
      check("idle_outputs", {m_hdr_tvalid, m_axis_tvalid, m_axis_tlast, m_axis_tdata,
                             m_grant, s_hdr_trdy, s_axis_trdy}, '0);
    end else begin
      g = int'(m_grant);
      if (!prev_busy) begin
        e = rr_pick(snap, last_sent);
        check("grant", 32'(g), 32'(e));
        grant_code = (grant_code << 4) | 32'(g);
        $display("grant port %0d (expected %0d) requests=%b", g, e, snap);
      end
      mask = '0;
      mask[g] = 1'b1;
      check("other_readies", {s_hdr_trdy & ~mask, s_axis_trdy & ~mask}, '0);
      if (phase[g] == 0) begin
        check("hdr_valid", {m_hdr_tvalid, m_axis_tvalid}, 2'b10);
        check("hdr_fields", {m_udp_src_port, m_udp_dst_port, m_ip_src_ip_addr,
                             m_ip_dst_ip_addr, m_ip_protocol},
              {h_src[g], h_dst[g], h_sip[g], h_dip[g], h_proto[g]});
        check("hdr_ready", s_hdr_trdy[g], m_hdr_trdy);
      end else begin
        check("pay_valid", {m_hdr_tvalid, m_axis_tvalid}, {1'b0, s_axis_tvalid[g]});
        if (s_axis_tvalid[g])
          check("pay_data", {m_axis_tdata, m_axis_tlast},
                {byte_val(g, seq[g], idx[g]), idx[g] == len[g] - 1});
        check("pay_ready", s_axis_trdy[g], m_axis_trdy);
      end
    end
    prev_busy = m_busy;
  endtask

  task automatic apply();
    for (int p = 0; p < N; p++) begin
      if (hs_hdr[p]) phase[p] = 1;
      if (hs_ax[p]) begin
        if (idx[p] == len[p] - 1) begin
          pend[p]--; phase[p] = 0; seq[p]++; last_sent = p; done_cnt[p]++;
          exp_bytes += len[p]; exp_pkts++;
          if (pend[p] > 0) new_header(p);
        end else begin
          idx[p]++;
        end
      end
      hold[p] = s_axis_tvalid[p] && !hs_ax[p];
    end
  endtask

  task automatic run(input int max_cyc, input int stop_idx, output bit ab);
    int cyc = 0;
    bit stop;
    ab = 0;
    grant_code = 32'h1;
    while (total_pend() > 0) begin
      if (cyc >= max_cyc) begin
        check("timeout_pending", 32'(total_pend()), 32'd0);
        break;
      end
      @(negedge i_clk); drive(); #1; sample_and_check();
      @(posedge i_clk); apply();
      cyc++;
      if (stop_idx > 0) begin
        stop = 0;
        for (int p = 0; p < N; p++) if (phase[p] == 1 && idx[p] == stop_idx) stop = 1;
        if (stop) begin ab = 1; break; end
      end
    end
    if (!ab) begin
      check("bytes_out", 32'(out_bytes), 32'(exp_bytes));
      check("pkts_out", 32'(out_pkts), 32'(exp_pkts));
    end
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    i_reset = 1'b1;
    reset_model();
    drive();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    salt = $urandom;
    tog = 0; rdy_mode = 1;
    reset_model();
    i_reset = 1'b0;
    drive();
    m_hdr_trdy = 1'b0; m_axis_trdy = 1'b0;
    #1 i_reset = 1'b1;
    #1 check_all_zero("reset_outputs");
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;

    // Single requester, fixed header, 5-byte payload.
    enqueue(2, 1, 5);
    h_src[2] = 16'h1234; h_dst[2] = 16'h5678;
    run(200, 0, aborted);
    check("single_port2_order", grant_code, 32'h12);
    @(negedge i_clk); drive(); #1;
    check("idle_after_tlast", m_busy, 1'b0);

    // Three simultaneous requesters right after reset.
    reset_dut();
    rdy_mode = 0;
    enqueue(0, 1, 0); enqueue(1, 1, 0); enqueue(3, 1, 0);
    run(500, 0, aborted);
    check("order_0_1_3", grant_code, 32'h1013);

    // Port 1 comes back while port 3 waits: 3 must go before 1's second packet.
    reset_dut();
    enqueue(1, 2, 0); enqueue(3, 1, 0);
    run(500, 0, aborted);
    check("order_1_3_1", grant_code, 32'h1131);

    // Payload ready toggling every cycle.
    rdy_mode = 2;
    enqueue(0, 1, 8);
    run(200, 0, aborted);
    check("toggle_order", grant_code, 32'h10);

    // Randomised rounds.
    for (int r = 0; r < 6; r++) begin
      rdy_mode = int'($urandom_range(0, 2));
      for (int p = 0; p < N; p++) enqueue(p, int'($urandom_range(0, 3)), 0);
      enqueue(int'($urandom_range(0, N - 1)), 1, 0);
      run(3000, 0, aborted);
    end

    // Reset while the third byte of a 10-byte packet is on the bus.
    rdy_mode = 1;
    enqueue(0, 1, 10);
    run(200, 2, aborted);
    check("abort_reached", aborted, 1'b1);
    #2 i_reset = 1'b1;
    #1 check_all_zero("midpacket_reset");
    reset_model();
    repeat (2) @(negedge i_clk);
    drive();
    i_reset = 1'b0;
    enqueue(0, 1, 0); enqueue(2, 1, 0);
    run(300, 0, aborted);
    check("after_reset_order", grant_code, 32'h102);

    // Three packets from port 0, two from port 2.
    reset_dut();
    rdy_mode = 0;
    enqueue(0, 3, 0); enqueue(2, 2, 0);
    run(1000, 0, aborted);
    check("stats_run_order", grant_code, 32'h102020);
`ifdef UDP_TX_ARB_STATS_EN
    @(negedge i_clk); #1;
    for (int p = 0; p < N; p++)
      check("pkt_count", m_pkt_count[32*p +: 32], (p == 0) ? 32'd3 : (p == 2) ? 32'd2 : 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
